// File: rtl/mem_load_unit_pkg.sv
// Shared opcodes, bus size codes and load/store-unit FSM states for the MEM-stage load path.
package mem_load_unit_pkg;

  localparam logic [5:0] EXE_LB  = 6'b100000;
  localparam logic [5:0] EXE_LH  = 6'b100001;
  localparam logic [5:0] EXE_LW  = 6'b100011;
  localparam logic [5:0] EXE_LBU = 6'b100100;
  localparam logic [5:0] EXE_LHU = 6'b100101;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_DONE,
    LSU_DRAIN
  } lsu_state_e;

  // Anything that is not a byte/half load goes out as a full word.
  function automatic logic [1:0] op_size(input logic [5:0] op);
    case (op)
      EXE_LB, EXE_LBU: op_size = SIZE_B;
      EXE_LH, EXE_LHU: op_size = SIZE_H;
      default:         op_size = SIZE_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_unit_align.sv
// Picks the addressed byte/half out of the returned word and sign/zero-extends it.
module load_align
  import mem_load_unit_pkg::*;
(
  input  logic [5:0]  op_code,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{addr, 3'b000} +: 8];
    h = rdata[{addr[1], 4'b0000} +: 16];
    case (op_code)
      EXE_LB:  result = {{24{b[7]}}, b};
      EXE_LBU: result = {24'h0, b};
      EXE_LH:  result = {{16{h[15]}}, h};
      EXE_LHU: result = {16'h0, h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// MEM-stage load unit: one outstanding SRAM-like read, stalls MEM until data returns,
// then holds the aligned result in DONE until WB takes it.
module mem_load_unit
  import mem_load_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  op_code,
  input  logic [31:0] addr,
  input  logic        load_valid,
  input  logic        flush,
  input  logic        wb_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  input  logic        data_addr_ok,
  input  logic [31:0] data_rdata,
  input  logic        data_data_ok,
  output logic [31:0] load_result,
  output logic        load_done,
  output logic        mem_stall,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_e    state_q, state_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic [5:0]    op_q, op_d;
  logic [31:0]   res_q, res_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   aligned;
  logic          tmo_hit;

  load_align u_align (
    .op_code (op_q),
    .addr    (addr_q[1:0]),
    .rdata   (data_rdata),
    .result  (aligned)
  );

  assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    size_d  = size_q;
    op_d    = op_q;
    res_d   = res_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      LSU_IDLE: begin
        if (load_valid && !flush) begin
          op_d    = op_code;
          addr_d  = addr;
          size_d  = op_size(op_code);
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = LSU_REQ;
        end
      end
      LSU_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (flush) begin
          // An accepted address still owes us a data beat unless it came back already.
          req_d   = 1'b0;
          state_d = (data_addr_ok && !data_data_ok) ? LSU_DRAIN : LSU_IDLE;
        end else if (data_addr_ok && data_data_ok) begin
          req_d   = 1'b0;
          res_d   = aligned;
          state_d = LSU_DONE;
        end else if (tmo_hit) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = LSU_IDLE;
        end else if (data_addr_ok) begin
          req_d   = 1'b0;
          state_d = LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (data_data_ok) begin
          if (!flush) res_d = aligned;
          state_d = flush ? LSU_IDLE : LSU_DONE;
        end else if (flush) begin
          state_d = LSU_DRAIN;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = LSU_IDLE;
        end
      end
      LSU_DONE: begin
        if (flush || !wb_stall) state_d = LSU_IDLE;
      end
      LSU_DRAIN: begin
        if (data_data_ok) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= LSU_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      size_q  <= SIZE_W;
      op_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_req    = req_q;
  assign data_wr     = 1'b0;
  assign data_size   = size_q;
  assign data_addr   = addr_q;
  assign load_result = res_q;
  assign load_done   = (state_q == LSU_DONE);
  assign bus_err     = err_q;
  assign mem_stall   = (load_valid && !load_done) || (state_q == LSU_DRAIN);

endmodule
